// File: rtl/pq_req_arb.sv
// pq_req_arb -- shares one hardware priority queue between N_REQ requesters.
//
// Requests are serialized through a four-state FSM (IDLE, ISSUE, WAIT, DONE).
// A granted request is checked against the queue's full/empty flags, turned
// into a single-cycle enq/deq strobe, held until the queue drops busy, and
// answered with a one-cycle one-hot acknowledge (plus err and the head value).
//
// Build option:
//   PQ_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins.
//                         undefined -> round-robin starting at requester 0.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   req_i          per-requester request, held until its ack
//   op_i           per-requester opcode: 01 ENQ, 10 DEQ, 11 REPLACE, 00 illegal
//   kvi_i          per-requester key/value, sampled at grant
//   ack_o          one-hot completion pulse
//   err_o          with ack: request rejected, no queue operation performed
//   kvo_o          head value captured by the last DEQ/REPLACE
//   arb_busy_o     FSM not idle
//   pq_enq_o, pq_deq_o, pq_kvi_o          drive the queue
//   pq_kvo_i, pq_busy_i, pq_full_i, pq_empty_i   queue head and status
module pq_req_arb #(
    parameter int N_REQ = 4,
    parameter int KVW   = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_i,
    input  logic [N_REQ-1:0][1:0]     op_i,
    input  logic [N_REQ-1:0][KVW-1:0] kvi_i,
    output logic [N_REQ-1:0]          ack_o,
    output logic                      err_o,
    output logic [KVW-1:0]            kvo_o,
    output logic                      arb_busy_o,
    output logic                      pq_enq_o,
    output logic                      pq_deq_o,
    output logic [KVW-1:0]            pq_kvi_o,
    input  logic [KVW-1:0]            pq_kvo_i,
    input  logic                      pq_busy_i,
    input  logic                      pq_full_i,
    input  logic                      pq_empty_i
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [1:0] OP_ENQ = 2'b01;
    localparam logic [1:0] OP_DEQ = 2'b10;
    localparam logic [1:0] OP_RPL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t         state_q;
    logic [IW-1:0]  gnt_q;
    logic [IW-1:0]  gnt_d;
    logic [1:0]     op_q;
    logic [KVW-1:0] kvi_q;
    logic [KVW-1:0] kvo_q;
    logic           err_q;
    logic           found;
    logic           grant;
    logic           legal;
    logic [IW-1:0]  cand;
    int             pick_idx;
`ifndef PQ_ARB_FIXED_PRIO_EN
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  ptr_d;
`endif

    // Winner search: first asserted request scanning upward from the start
    // index, wrapping at N_REQ.
    always_comb begin
        found    = 1'b0;
        gnt_d    = '0;
        pick_idx = 0;
        cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef PQ_ARB_FIXED_PRIO_EN
            pick_idx = k;
`else
            pick_idx = int'(ptr_q) + k;
            if (pick_idx >= N_REQ) pick_idx = pick_idx - N_REQ;
`endif
            cand = IW'(pick_idx);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                gnt_d = cand;
            end
        end
    end

`ifndef PQ_ARB_FIXED_PRIO_EN
    assign ptr_d = (gnt_d == IW'(N_REQ - 1)) ? '0 : gnt_d + IW'(1);
`endif

    assign grant = (state_q == S_IDLE) && found && !pq_busy_i;

    // Legality uses the queue flags as seen in the ISSUE cycle itself.
    // REPLACE leaves the count unchanged, so only an empty queue rejects it.
    always_comb begin
        legal = 1'b0;
        case (op_q)
            OP_ENQ:         legal = !pq_full_i;
            OP_DEQ, OP_RPL: legal = !pq_empty_i;
            default:        legal = 1'b0;
        endcase
    end

    // Strobes and pq_kvi exist only in the ISSUE cycle of a legal request.
    assign pq_enq_o   = (state_q == S_ISSUE) && legal && op_q[0];
    assign pq_deq_o   = (state_q == S_ISSUE) && legal && op_q[1];
    assign pq_kvi_o   = ((state_q == S_ISSUE) && legal) ? kvi_q : '0;
    assign arb_busy_o = (state_q != S_IDLE);
    assign err_o      = (state_q == S_DONE) && err_q;
    assign kvo_o      = kvo_q;

    always_comb begin
        ack_o = '0;
        if (state_q == S_DONE) ack_o[gnt_q] = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            op_q    <= 2'b00;
            err_q   <= 1'b0;
            kvo_q   <= '0;
`ifndef PQ_ARB_FIXED_PRIO_EN
            ptr_q   <= '0;
`endif
        end else begin
            case (state_q)
                // Grant: latch winner and its opcode
                S_IDLE: begin
                    if (grant) begin
                        gnt_q   <= gnt_d;
                        op_q    <= op_i[gnt_d];
                        err_q   <= 1'b0;
`ifndef PQ_ARB_FIXED_PRIO_EN
                        ptr_q   <= ptr_d;
`endif
                        state_q <= S_ISSUE;
                    end
                end
                // Issue: strobe the queue or reject; head captured before removal
                S_ISSUE: begin
                    if (legal) begin
                        if (op_q[1]) kvo_q <= pq_kvo_i;
                        state_q <= S_WAIT;
                    end else begin
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                // Wait: at least one cycle, until the queue is idle
                S_WAIT: begin
                    if (!pq_busy_i) state_q <= S_DONE;
                end
                // Done: acknowledge for one cycle
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Key/value payload needs no reset: it only reaches pq_kvi in ISSUE.
    always_ff @(posedge clk_i) begin
        if (grant) kvi_q <= kvi_i[gnt_d];
    end

endmodule

// File: tb/tb_pq_req_arb.sv
module tb_pq_req_arb;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int DEPTH = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req;
    logic [N-1:0][1:0]   op;
    logic [N-1:0][W-1:0] kvi;
    logic [N-1:0]        ack;
    logic                err;
    logic [W-1:0]        kvo;
    logic                arb_busy;
    logic                pq_enq;
    logic                pq_deq;
    logic [W-1:0]        pq_kvi;
    logic [W-1:0]        pq_kvo;
    logic                pq_busy;
    logic                pq_full;
    logic                pq_empty;

    pq_req_arb #(.N_REQ(N), .KVW(W)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .op_i(op), .kvi_i(kvi),
        .ack_o(ack), .err_o(err), .kvo_o(kvo), .arb_busy_o(arb_busy),
        .pq_enq_o(pq_enq), .pq_deq_o(pq_deq), .pq_kvi_o(pq_kvi),
        .pq_kvo_i(pq_kvo), .pq_busy_i(pq_busy), .pq_full_i(pq_full),
        .pq_empty_i(pq_empty)
    );

    always #5 clk = ~clk;

    // Queue model: largest key is the head; busy for busy_len cycles per op.
    logic [W-1:0] mq[$];
    int           busy_cnt = 0;
    int           busy_len = 0;
    logic         empty_m = 1'b1;
    logic         full_m = 1'b0;
    logic [W-1:0] head_m = '0;
    logic         force_full = 1'b0;
    logic         force_empty = 1'b0;

    assign pq_kvo   = head_m;
    assign pq_busy  = (busy_cnt != 0);
    assign pq_full  = full_m | force_full;
    assign pq_empty = empty_m | force_empty;

    function automatic int head_idx();
        int h = 0;
        for (int i = 1; i < mq.size(); i++) if (mq[i] > mq[h]) h = i;
        return h;
    endfunction

    always @(posedge clk) begin
        if (pq_deq && mq.size() > 0) mq.delete(head_idx());
        if (pq_enq) mq.push_back(pq_kvi);
        busy_cnt <= (pq_enq || pq_deq) ? busy_len : ((busy_cnt > 0) ? busy_cnt - 1 : 0);
        empty_m  <= (mq.size() == 0);
        full_m   <= (mq.size() >= DEPTH);
        head_m   <= (mq.size() == 0) ? '0 : mq[head_idx()];
    end

    typedef struct {
        logic [N-1:0] ack;
        logic         err;
        logic [W-1:0] kvo;
        int           cyc;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] exp_kvo = '0;

    function automatic logic [N-1:0] onehot(input int i);
        return N'(1) << i;
    endfunction

    task automatic launch(input int who, input logic [1:0] o, input logic [W-1:0] kv);
        @(posedge clk); #1;
        op[who]  = o;
        kvi[who] = kv;
        req      = req | onehot(who);
    endtask

    // Cycle 0 is the first negedge after launch; stops at the first ack.
    task automatic observe(input int maxc, output int ack_cyc, output logic [N-1:0] a,
                           output logic e, output logic [W-1:0] k, output int enq_cyc,
                           output int n_enq, output int n_deq, output logic [W-1:0] kvi_at);
        ack_cyc = -1; a = '0; e = 1'b0; k = '0; enq_cyc = -1;
        n_enq = 0; n_deq = 0; kvi_at = '0;
        for (int c = 0; c <= maxc; c++) begin
            @(negedge clk);
            if (pq_enq) begin
                n_enq++;
                if (enq_cyc < 0) begin enq_cyc = c; kvi_at = pq_kvi; end
            end
            if (pq_deq) n_deq++;
            if (ack !== '0) begin
                ack_cyc = c; a = ack; e = err; k = kvo;
                req = '0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '1; op = '{default: 2'b01}; kvi = '{default: 16'h1111};
        #1;
        n_cmp++; if (ack !== '0)      begin n_bad++; $display("FAIL rst_ack got %b want 0", ack); end
        n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL rst_err got %b want 0", err); end
        n_cmp++; if (kvo !== '0)      begin n_bad++; $display("FAIL rst_kvo got %h want 0", kvo); end
        n_cmp++; if (pq_enq !== 1'b0) begin n_bad++; $display("FAIL rst_enq got %b want 0", pq_enq); end
        n_cmp++; if (pq_deq !== 1'b0) begin n_bad++; $display("FAIL rst_deq got %b want 0", pq_deq); end
        n_cmp++; if (pq_kvi !== '0)   begin n_bad++; $display("FAIL rst_pq_kvi got %h want 0", pq_kvi); end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", arb_busy); end
        req = '0;
        rst = 1'b0;
        exp_kvo = '0;
    endtask

    task automatic test_single_enq;
        int ac, ec, ne, nd; logic [N-1:0] a; logic e; logic [W-1:0] k, ka; exp_t ex;
        launch(2, 2'b01, 16'h0A05);
        sb.push_back('{4'b0100, 1'b0, exp_kvo, 3});
        observe(20, ac, a, e, k, ec, ne, nd, ka);
        ex = sb.pop_front();
        n_cmp++; if (ac !== ex.cyc)     begin n_bad++; $display("FAIL enq_ack_cycle got %0d want %0d", ac, ex.cyc); end
        n_cmp++; if (a !== ex.ack)      begin n_bad++; $display("FAIL enq_ack got %b want %b", a, ex.ack); end
        n_cmp++; if (e !== ex.err)      begin n_bad++; $display("FAIL enq_err got %b want %b", e, ex.err); end
        n_cmp++; if (k !== ex.kvo)      begin n_bad++; $display("FAIL enq_kvo got %h want %h", k, ex.kvo); end
        n_cmp++; if (ec !== 1)          begin n_bad++; $display("FAIL enq_strobe_cycle got %0d want 1", ec); end
        n_cmp++; if (ne !== 1 || nd !== 0) begin n_bad++; $display("FAIL enq_strobe_count got %0d/%0d want 1/0", ne, nd); end
        n_cmp++; if (ka !== 16'h0A05)   begin n_bad++; $display("FAIL enq_pq_kvi got %h want 0a05", ka); end
    endtask

    task automatic test_deq;
        logic [1:0]   op_t[4] = '{2'b01, 2'b01, 2'b10, 2'b10};
        logic [W-1:0] kv_t[4] = '{16'h0003, 16'h0009, 16'h0000, 16'h0000};
        logic [W-1:0] ko_t[4] = '{16'h0000, 16'h0000, 16'h0A05, 16'h0009};
        int ac, ec, ne, nd; logic [N-1:0] a; logic e; logic [W-1:0] k, ka; exp_t ex;
        for (int i = 0; i < 4; i++) begin
            launch(0, op_t[i], kv_t[i]);
            sb.push_back('{4'b0001, 1'b0, ko_t[i], 3});
            observe(20, ac, a, e, k, ec, ne, nd, ka);
            ex = sb.pop_front();
            n_cmp++; if (ac !== ex.cyc) begin n_bad++; $display("FAIL deq_ack_cycle[%0d] got %0d want %0d", i, ac, ex.cyc); end
            n_cmp++; if (a !== ex.ack)  begin n_bad++; $display("FAIL deq_ack[%0d] got %b want %b", i, a, ex.ack); end
            n_cmp++; if (e !== ex.err)  begin n_bad++; $display("FAIL deq_err[%0d] got %b want %b", i, e, ex.err); end
            n_cmp++; if (k !== ex.kvo)  begin n_bad++; $display("FAIL deq_kvo[%0d] got %h want %h", i, k, ex.kvo); end
            n_cmp++; if (ne !== int'(op_t[i][0]) || nd !== int'(op_t[i][1]))
                begin n_bad++; $display("FAIL deq_strobes[%0d] got %0d/%0d want %0d/%0d", i, ne, nd, op_t[i][0], op_t[i][1]); end
        end
        exp_kvo = 16'h0009;
        @(negedge clk);
        n_cmp++; if (pq_empty !== 1'b0) begin n_bad++; $display("FAIL deq_not_empty got %b want 0", pq_empty); end
    endtask

    task automatic test_round_robin;
        int order[4]; int got; int last; exp_t ex;
`ifdef PQ_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0};
`else
        order = '{0, 1, 3, 0};
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_kvo = '0;
        for (int i = 0; i < 4; i++) sb.push_back('{onehot(order[i]), 1'b0, 16'h0000, 3 + 4 * i});
        @(posedge clk); #1;
        op[0] = 2'b01; op[1] = 2'b01; op[3] = 2'b01;
        kvi[0] = 16'h0100; kvi[1] = 16'h0101; kvi[3] = 16'h0103;
        req = 4'b1011;
        got = 0; last = 0;
        for (int c = 0; c < 80 && got < 4; c++) begin
            @(negedge clk);
            if (ack !== '0) begin
                ex = sb.pop_front();
                n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL rr_order[%0d] got %b want %b", got, ack, ex.ack); end
                n_cmp++; if (c !== ex.cyc)   begin n_bad++; $display("FAIL rr_cycle[%0d] got %0d want %0d", got, c, ex.cyc); end
                n_cmp++; if (err !== ex.err || kvo !== ex.kvo)
                    begin n_bad++; $display("FAIL rr_err_kvo[%0d] got %b/%h want %b/%h", got, err, kvo, ex.err, ex.kvo); end
                got++;
                if (got == 4) req = '0;
            end
        end
        req = '0;
        n_cmp++; if (got !== 4) begin n_bad++; $display("FAIL rr_ack_count got %0d want 4", got); end
        sb.delete();
    endtask

    task automatic test_illegal;
        int           who_t[4] = '{1, 2, 3, 0};
        logic [1:0]   op_t[4]  = '{2'b10, 2'b01, 2'b00, 2'b11};
        logic         ff_t[4]  = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic         fe_t[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
        int ac, ec, ne, nd; logic [N-1:0] a; logic e; logic [W-1:0] k, ka; exp_t ex;
        for (int i = 0; i < 4; i++) begin
            force_full = ff_t[i]; force_empty = fe_t[i];
            launch(who_t[i], op_t[i], 16'h0777);
            sb.push_back('{onehot(who_t[i]), 1'b1, exp_kvo, 2});
            observe(20, ac, a, e, k, ec, ne, nd, ka);
            ex = sb.pop_front();
            force_full = 1'b0; force_empty = 1'b0;
            n_cmp++; if (ac !== ex.cyc) begin n_bad++; $display("FAIL ill_ack_cycle[%0d] got %0d want %0d", i, ac, ex.cyc); end
            n_cmp++; if (a !== ex.ack)  begin n_bad++; $display("FAIL ill_ack[%0d] got %b want %b", i, a, ex.ack); end
            n_cmp++; if (e !== ex.err)  begin n_bad++; $display("FAIL ill_err[%0d] got %b want %b", i, e, ex.err); end
            n_cmp++; if (k !== ex.kvo)  begin n_bad++; $display("FAIL ill_kvo[%0d] got %h want %h", i, k, ex.kvo); end
            n_cmp++; if (ne !== 0 || nd !== 0) begin n_bad++; $display("FAIL ill_strobes[%0d] got %0d/%0d want 0/0", i, ne, nd); end
        end
    endtask

    task automatic test_replace;
        int ac, ec, ne, nd, pre; logic [N-1:0] a; logic e; logic [W-1:0] k, ka; exp_t ex;
        pre = mq.size();
        launch(1, 2'b11, 16'h0001);
        sb.push_back('{4'b0010, 1'b0, 16'h0103, 3});
        observe(20, ac, a, e, k, ec, ne, nd, ka);
        ex = sb.pop_front();
        n_cmp++; if (ac !== ex.cyc) begin n_bad++; $display("FAIL rpl_ack_cycle got %0d want %0d", ac, ex.cyc); end
        n_cmp++; if (a !== ex.ack)  begin n_bad++; $display("FAIL rpl_ack got %b want %b", a, ex.ack); end
        n_cmp++; if (e !== ex.err)  begin n_bad++; $display("FAIL rpl_err got %b want %b", e, ex.err); end
        n_cmp++; if (k !== ex.kvo)  begin n_bad++; $display("FAIL rpl_kvo got %h want %h", k, ex.kvo); end
        n_cmp++; if (ne !== 1 || nd !== 1 || ec !== 1)
            begin n_bad++; $display("FAIL rpl_strobes got %0d/%0d at %0d want 1/1 at 1", ne, nd, ec); end
        n_cmp++; if (ka !== 16'h0001) begin n_bad++; $display("FAIL rpl_pq_kvi got %h want 0001", ka); end
        n_cmp++; if (mq.size() !== pre) begin n_bad++; $display("FAIL rpl_count got %0d want %0d", mq.size(), pre); end
        exp_kvo = 16'h0103;
    endtask

    task automatic test_busy;
        int ac, ec, ne, nd; logic [N-1:0] a; logic e; logic [W-1:0] k, ka; exp_t ex;
        busy_len = 5;
        launch(2, 2'b01, 16'h0050);
        sb.push_back('{4'b0100, 1'b0, exp_kvo, 8});
        observe(30, ac, a, e, k, ec, ne, nd, ka);
        ex = sb.pop_front();
        busy_len = 0;
        n_cmp++; if (ac !== ex.cyc) begin n_bad++; $display("FAIL busy_ack_cycle got %0d want %0d", ac, ex.cyc); end
        n_cmp++; if (a !== ex.ack)  begin n_bad++; $display("FAIL busy_ack got %b want %b", a, ex.ack); end
        n_cmp++; if (e !== ex.err || k !== ex.kvo) begin n_bad++; $display("FAIL busy_err_kvo got %b/%h want %b/%h", e, k, ex.err, ex.kvo); end
        n_cmp++; if (ne !== 1)      begin n_bad++; $display("FAIL busy_strobe_count got %0d want 1", ne); end
    endtask

    task automatic test_reset_mid;
        int spur; int got; exp_t ex;
        busy_len = 5;
        launch(2, 2'b01, 16'h0060);
        repeat (3) @(negedge clk);
        n_cmp++; if (arb_busy !== 1'b1) begin n_bad++; $display("FAIL rm_busy_in_wait got %b want 1", arb_busy); end
        rst = 1'b1;
        #1;
        n_cmp++; if (ack !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL rm_ack_err got %b/%b want 0/0", ack, err); end
        n_cmp++; if (kvo !== '0)       begin n_bad++; $display("FAIL rm_kvo got %h want 0", kvo); end
        n_cmp++; if (arb_busy !== 1'b0) begin n_bad++; $display("FAIL rm_arb_busy got %b want 0", arb_busy); end
        n_cmp++; if (pq_enq !== 1'b0 || pq_deq !== 1'b0 || pq_kvi !== '0)
            begin n_bad++; $display("FAIL rm_strobes got %b/%b/%h want 0/0/0", pq_enq, pq_deq, pq_kvi); end
        req = '0;
        exp_kvo = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        busy_len = 0;
        spur = 0;
        repeat (10) begin @(negedge clk); if (ack !== '0) spur++; end
        n_cmp++; if (spur !== 0) begin n_bad++; $display("FAIL rm_spurious_ack got %0d want 0", spur); end
        sb.push_back('{4'b0001, 1'b0, 16'h0000, 3});
        sb.push_back('{4'b1000, 1'b0, 16'h0000, 7});
        @(posedge clk); #1;
        op[0] = 2'b01; op[3] = 2'b01; kvi[0] = 16'h0070; kvi[3] = 16'h0073;
        req = 4'b1001;
        got = 0;
        for (int c = 0; c < 40 && got < 2; c++) begin
            @(negedge clk);
            if (ack !== '0) begin
                ex = sb.pop_front();
                n_cmp++; if (ack !== ex.ack) begin n_bad++; $display("FAIL rm_order[%0d] got %b want %b", got, ack, ex.ack); end
                n_cmp++; if (c !== ex.cyc || kvo !== ex.kvo)
                    begin n_bad++; $display("FAIL rm_cycle_kvo[%0d] got %0d/%h want %0d/%h", got, c, kvo, ex.cyc, ex.kvo); end
                req = req & ~ack;
                got++;
            end
        end
        req = '0;
        n_cmp++; if (got !== 2) begin n_bad++; $display("FAIL rm_ack_count got %0d want 2", got); end
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_single_enq();
        test_deq();
        test_round_robin();
        test_illegal();
        test_replace();
        test_busy();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired: compared %0d, mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
